// File: rtl/sh_rx_pkg.sv
// Shared types and defaults for the shift-register link receiver.
package sh_rx_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;
    localparam int unsigned CNT_W         = $clog2(WIDTH_DEFAULT);

    typedef enum logic {
        IDLE,
        SHIFT
    } rx_state_t;

    typedef enum logic {
        EMPTY,
        FULL
    } out_state_t;

endpackage

// File: rtl/sh_rgst_rx_if.sv
// Serial input, resync and parallel word handshake of the receiver.
interface sh_rgst_rx_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic             sh_in;
    logic             sh;
    logic             clr;
    logic             q_rdy;
    logic [WIDTH-1:0] q;
    logic             q_vld;
    logic             busy;
    logic             ovr;
    logic [CNT_W-1:0] cnt;

    // Transmitter/consumer side.
    modport master (
        output sh_in, sh, clr, q_rdy,
        input  q, q_vld, busy, ovr, cnt
    );

    // Receiver side.
    modport slave (
        input  sh_in, sh, clr, q_rdy,
        output q, q_vld, busy, ovr, cnt
    );

endinterface

// File: rtl/sh_rx_core.sv
// Bit collector: shift register, bit counter and receive FSM.
// word/word_done present the assembled word during the completing strobe.
module sh_rx_core
    import sh_rx_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sh_in,
    input  logic                     sh,
    input  logic                     clr,
    output logic [WIDTH-1:0]         word,
    output logic                     word_done,
    output logic [$clog2(WIDTH)-1:0] cnt
);
    localparam int unsigned cnt_w = $clog2(WIDTH);

    rx_state_t        state_q, state_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] sr_shifted;

    // Shift-in of the current bit; the completing word includes it.
    always_comb begin
        if (MSB_FIRST) begin
            sr_shifted = {sr_q[WIDTH-2:0], sh_in};
        end else begin
            sr_shifted = {sh_in, sr_q[WIDTH-1:1]};
        end
    end

    // Next-state: clr beats sh; the WIDTH-th strobe wraps cnt and completes the word.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        word_done = 1'b0;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            sr_d    = '0;
        end else if (sh) begin
            sr_d = sr_shifted;
            unique case (state_q)
                IDLE: begin
                    cnt_d   = cnt_w'(1);
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (cnt_q == cnt_w'(WIDTH - 1)) begin
                        cnt_d     = '0;
                        state_d   = IDLE;
                        word_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + cnt_w'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end

    assign word = sr_shifted;
    assign cnt  = cnt_q;

endmodule

// File: rtl/sh_rgst_rx.sv
// Serial-in, parallel-out receiver: holding register with valid/ready
// handshake and a sticky overrun flag on top of the bit collector.
module sh_rgst_rx
    import sh_rx_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic         clk,
    input logic         rst,
    sh_rgst_rx_if.slave bus
);
    logic [WIDTH-1:0] word;
    logic             word_done;

    out_state_t       out_state_q, out_state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             ovr_q, ovr_d;

    sh_rx_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .sh_in     (bus.sh_in),
        .sh        (bus.sh),
        .clr       (bus.clr),
        .word      (word),
        .word_done (word_done),
        .cnt       (bus.cnt)
    );

    // Output FSM: a completed word is loaded when the holding register is
    // empty or is being drained this cycle, otherwise it is dropped as overrun.
    always_comb begin
        out_state_d = out_state_q;
        q_d         = q_q;
        ovr_d       = ovr_q;
        unique case (out_state_q)
            EMPTY: begin
                if (word_done) begin
                    q_d         = word;
                    out_state_d = FULL;
                end
            end
            FULL: begin
                if (word_done) begin
                    if (bus.q_rdy) begin
                        q_d = word;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else if (bus.q_rdy) begin
                    out_state_d = EMPTY;
                end
            end
            default: out_state_d = EMPTY;
        endcase
        // word_done is never set alongside clr, so clearing here cannot mask an overrun.
        if (bus.clr) begin
            ovr_d = 1'b0;
        end
    end

    // Holding register, output state and overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_state_q <= EMPTY;
            q_q         <= '0;
            ovr_q       <= 1'b0;
        end else begin
            out_state_q <= out_state_d;
            q_q         <= q_d;
            ovr_q       <= ovr_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.q_vld = (out_state_q == FULL);
    assign bus.ovr   = ovr_q;
    assign bus.busy  = (bus.cnt != '0);

endmodule

// File: tb/tb_sh_rgst_rx.sv
// Bench for sh_rgst_rx: an MSB-first and an LSB-first instance share one
// stimulus stream and are compared every cycle against a bit-list model.
module tb_sh_rgst_rx;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    sh_rgst_rx_if #(.WIDTH(W)) bus_m ();
    sh_rgst_rx_if #(.WIDTH(W)) bus_l ();

    sh_rgst_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    sh_rgst_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    always #5 clk = ~clk;

    // Reference model: bits of the current word in arrival order.
    bit          bits[$];
    logic [15:0] m_qm = '0;
    logic [15:0] m_ql = '0;
    bit          m_vld = 1'b0;
    bit          m_ovr = 1'b0;

    function automatic logic [15:0] pack(input bit msb);
        logic [15:0] w = '0;
        for (int i = 0; i < W; i++) begin
            if (msb) w[W-1-i] = bits[i];
            else     w[i]     = bits[i];
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("q_msb",    32'(bus_m.q),     32'(m_qm));
        check("q_lsb",    32'(bus_l.q),     32'(m_ql));
        check("vld_msb",  32'(bus_m.q_vld), 32'(m_vld));
        check("vld_lsb",  32'(bus_l.q_vld), 32'(m_vld));
        check("ovr_msb",  32'(bus_m.ovr),   32'(m_ovr));
        check("ovr_lsb",  32'(bus_l.ovr),   32'(m_ovr));
        check("cnt_msb",  32'(bus_m.cnt),   32'(bits.size()));
        check("cnt_lsb",  32'(bus_l.cnt),   32'(bits.size()));
        check("busy_msb", 32'(bus_m.busy),  32'(bits.size() != 0));
        check("busy_lsb", 32'(bus_l.busy),  32'(bits.size() != 0));
    endtask

    // One clock: drive inputs, advance model across the edge, check #1 later.
    task automatic step(input logic s, input logic b, input logic c, input logic r,
                        input logic rs);
        bit          xfer;
        bit          done;
        logic [15:0] wm;
        logic [15:0] wl;
        rst         = rs;
        bus_m.sh    = s;  bus_l.sh    = s;
        bus_m.sh_in = b;  bus_l.sh_in = b;
        bus_m.clr   = c;  bus_l.clr   = c;
        bus_m.q_rdy = r;  bus_l.q_rdy = r;
        @(posedge clk);
        if (rs) begin
            bits.delete();
            m_vld = 1'b0;
            m_ovr = 1'b0;
            m_qm  = '0;
            m_ql  = '0;
        end else begin
            xfer = m_vld && r;
            done = 1'b0;
            wm   = '0;
            wl   = '0;
            if (c) begin
                bits.delete();
                m_ovr = 1'b0;
            end else if (s) begin
                bits.push_back(b);
                if (bits.size() == W) begin
                    done = 1'b1;
                    wm   = pack(1'b1);
                    wl   = pack(1'b0);
                    bits.delete();
                end
            end
            if (done) begin
                if (!m_vld || xfer) begin
                    m_qm  = wm;
                    m_ql  = wl;
                    m_vld = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (xfer) begin
                m_vld = 1'b0;
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, r, 1'b0);
    endtask

    // Sends one word in the given bit order, optionally with a gap before bit gap_at.
    task automatic send_word(input logic [15:0] w, input bit msb, input logic r,
                             input logic r_last, input int gap_at, input int gap_len);
        logic b;
        for (int i = 0; i < W; i++) begin
            if (i == gap_at) idle(gap_len, r);
            b = msb ? w[W-1-i] : w[i];
            step(1'b1, b, 1'b0, (i == W - 1) ? r_last : r, 1'b0);
        end
    endtask

    initial begin
        bus_m.sh = 1'b0; bus_m.sh_in = 1'b0; bus_m.clr = 1'b0; bus_m.q_rdy = 1'b0;
        bus_l.sh = 1'b0; bus_l.sh_in = 1'b0; bus_l.clr = 1'b0; bus_l.q_rdy = 1'b0;

        // Reset for two cycles, then explicit zero checks.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_q",   32'(bus_m.q),     32'h0);
        check("rst_vld", 32'(bus_m.q_vld), 32'h0);
        check("rst_cnt", 32'(bus_m.cnt),   32'h0);

        // Reset mid-word, then a fresh word.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("midrst_cnt",  32'(bus_m.cnt),  32'h0);
        check("midrst_busy", 32'(bus_m.busy), 32'h0);
        send_word(16'hC3A5, 1'b1, 1'b1, 1'b0, -1, 0);
        check("fresh_word", 32'(bus_m.q), 32'hC3A5);
        idle(1, 1'b1);

        // MSB-first word held until q_rdy pulse.
        send_word(16'hAB00, 1'b1, 1'b0, 1'b0, -1, 0);
        check("ab00_q",   32'(bus_m.q),     32'hAB00);
        check("ab00_vld", 32'(bus_m.q_vld), 32'h1);
        idle(3, 1'b0);
        idle(1, 1'b1);
        check("ab00_drain", 32'(bus_m.q_vld), 32'h0);

        // Back-to-back with a gap inside the first word.
        send_word(16'h1234, 1'b1, 1'b1, 1'b1, 5, 3);
        check("b2b_first", 32'(bus_m.q), 32'h1234);
        send_word(16'hFFFF, 1'b1, 1'b1, 1'b1, -1, 0);
        check("b2b_second", 32'(bus_m.q), 32'hFFFF);
        idle(2, 1'b1);

        // Overrun, then clr keeps the pending word.
        send_word(16'h00FF, 1'b1, 1'b0, 1'b0, -1, 0);
        send_word(16'h5A5A, 1'b1, 1'b0, 1'b0, -1, 0);
        check("ovr_q",   32'(bus_m.q),   32'h00FF);
        check("ovr_set", 32'(bus_m.ovr), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ovr_clr", 32'(bus_m.ovr),   32'h0);
        check("clr_vld", 32'(bus_m.q_vld), 32'h1);
        idle(1, 1'b1);

        // Completion coincides with a transfer.
        send_word(16'h0F0F, 1'b1, 1'b0, 1'b0, -1, 0);
        send_word(16'h7E81, 1'b1, 1'b0, 1'b1, -1, 0);
        check("sim_q",   32'(bus_m.q),     32'h7E81);
        check("sim_vld", 32'(bus_m.q_vld), 32'h1);
        check("sim_ovr", 32'(bus_m.ovr),   32'h0);
        idle(1, 1'b1);

        // Resync mid-word (with a strobe on the clr cycle), then LSB-first word.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word(16'h8001, 1'b1, 1'b0, 1'b0, -1, 0);
        check("resync_q", 32'(bus_m.q), 32'h8001);
        idle(1, 1'b1);
        send_word(16'hAB00, 1'b0, 1'b0, 1'b0, -1, 0);
        check("lsb_q", 32'(bus_l.q), 32'hAB00);
        idle(1, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(1'(($urandom % 4) != 0), 1'($urandom), 1'(($urandom % 40) == 0),
                 1'($urandom), 1'(($urandom % 250) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sh_rgst_rx.md
# sh_rgst_rx

Serial-in, parallel-out receiver for the 16-bit shift-register link. It collects bits arriving on `sh_in` under a per-bit `sh` strobe, frames them into WIDTH-bit words with an internal bit counter, and presents each completed word in a holding register with a valid/ready handshake. It sits at the far end of the serial path driven by the parallel-load/shift transmitter register. It also reports overruns and can be resynchronised mid-word.

## Interface
- `WIDTH`, 16: word length in bits; must be ≥2.
- `MSB_FIRST`, 1: 1 means the first received bit lands in `q[WIDTH-1]`; 0 means it lands in `q[0]`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `sh_in`  in  1  serial data bit; sampled only when `sh`=1.
- `sh`  in  1  bit strobe; one bit accepted per cycle with `sh`=1.
- `clr`  in  1  synchronous resync: discards the partial word and clears `ovr`.
- `q`  out  WIDTH  holding register, i.e. the last completed word.
- `q_vld`  out  1  `q` holds an unconsumed word.
- `q_rdy`  in  1  consumer accepts `q` when `q_vld`&&`q_rdy`.
- `busy`  out  1  a partial word is in progress (bit count ≠ 0).
- `ovr`  out  1  sticky overrun flag.
- `cnt`  out  $clog2(WIDTH)  number of bits collected in the current word.

## Operation
- Receive FSM has two states:
  - IDLE: `cnt`=0.
  - SHIFT: 1 ≤ `cnt` ≤ WIDTH-1.
- IDLE→SHIFT on `sh`=1.
- In SHIFT, each `sh`=1 increments `cnt`. The strobe that makes WIDTH bits is the completing strobe: `cnt` wraps to 0 and the FSM returns to IDLE.
- Shift register `sr`:
  - `MSB_FIRST`=1: `sr <= {sr[WIDTH-2:0], sh_in}`.
  - `MSB_FIRST`=0: `sr <= {sh_in, sr[WIDTH-1:1]}`.
- On the completing strobe the assembled word, including the current `sh_in`, is the candidate for `q`.
- Output FSM has two states: EMPTY (`q_vld`=0) and FULL (`q_vld`=1).
  - The completing strobe in EMPTY loads `q` and moves to FULL.
  - A transfer (`q_vld`&&`q_rdy`) in FULL with no completing strobe moves to EMPTY; `q` holds its last value.
  - Completing strobe and transfer in the same cycle: `q` loads the new word and the state stays FULL. There is no bubble and no overrun.
  - Completing strobe in FULL without a transfer: the new word is dropped, `q` is unchanged, and `ovr` is set to 1. Bit reception continues normally.
- `clr`=1:
  - Forces `cnt`=0, `sr`=0, IDLE, and `ovr`=0.
  - `q`/`q_vld` are not affected, so a pending word is still delivered.
  - A strobe in the same cycle as `clr` is ignored.
- `rst` has priority over `clr`. `clr` has priority over `sh`.
- `busy` = (`cnt`≠0).

## Timing
- Reset values: `q`=0, `q_vld`=0, `ovr`=0, `busy`=0, `cnt`=0; internal `sr`=0.
- Reset asserted mid-word: the partial word is lost and the next strobe after reset release is bit 0.
- Latency: `q`/`q_vld` update on the edge that samples the completing strobe. They are visible in the following cycle, i.e. 1 cycle after the last bit.
- Minimum word period is WIDTH cycles with `sh` held at 1. Back-to-back words are sustained as long as `q_rdy`=1.
- Gaps in `sh` are allowed anywhere; there is no timeout.
- `q_rdy` is ignored when `q_vld`=0.

## Structure
- Package `sh_rx_pkg`:
  - `rx_state_t` {IDLE, SHIFT};
  - `out_state_t` {EMPTY, FULL};
  - default `WIDTH` localparam;
  - `CNT_W` = $clog2(WIDTH).
- One sub-module, `sh_rx_core`. It holds `sr`, `cnt` and the receive FSM, and outputs `word`/`word_done`.
- The top level `sh_rgst_rx` holds the output register, output FSM and overrun logic.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles → all outputs 0. Assert `rst` after 5 bits → `cnt`=0, `busy`=0, and the next 16 bits form a fresh word.
- **MSB-first word:** shift 0xAB00 MSB-first with `sh`=1 for 16 consecutive cycles and `q_rdy`=0 → `q`=16'hAB00, `q_vld`=1 on cycle 17. `q_vld` stays 1 until `q_rdy` is pulsed, then drops the next cycle.
- **Back-to-back with gaps:** send 0x1234 then 0xFFFF, `q_rdy`=1, with 3 idle `sh`=0 cycles inside the first word → `q`=0x1234 then 0xFFFF, with `q_vld` high for exactly one cycle each, and `ovr`=0.
- **Overrun:** send 0x00FF with `q_rdy`=0, then send 0x5A5A → `q` stays 0x00FF and `ovr`=1. Pulsing `clr` → `ovr`=0 and `q_vld` still 1.
- **Simultaneous:** 2nd word completes in the same cycle as `q_rdy`=1 → `q` updates to the 2nd word, `q_vld` stays 1, and `ovr`=0.
- **Resync and LSB-first:** `clr` after 7 bits, then 16 bits of 0x8001 → `q`=0x8001. Repeat with `MSB_FIRST`=0, sending 0xAB00 LSB-first (bit 0 first) → `q`=0xAB00.
